pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants, state encoding and stall-mask helper for
// the pipeline controller.
//   STALL_W      width of the per-register stall bus (bit0 pc .. bit4 mem/wb)
//   WORD_W       address width
//   CNT_W        divide timeout counter width
//   DIV_TIMEOUT  divide cycles allowed before the sticky timeout flag is set
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W     = 5;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned DIV_TIMEOUT = 40;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [WORD_W-1:0] PC_INIT   = 32'hBFC0_0000;
  localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_EXC_PEND = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  // Thermometer mask holding the lowest `depth` pipeline registers, so a
  // stall pattern can never have a released register below a held one.
  function automatic logic [STALL_W-1:0] stall_upto(input int unsigned depth);
    logic [STALL_W-1:0] m;
    m = {STALL_W{NOSTOP}};
    for (int unsigned i = 0; i < STALL_W; i++) begin
      if (i < depth) m[i] = STOP;
    end
    return m;
  endfunction

  localparam logic [STALL_W-1:0] STALL_NONE = stall_upto(0);
  localparam logic [STALL_W-1:0] STALL_IBUS = stall_upto(2);
  localparam logic [STALL_W-1:0] STALL_ID   = stall_upto(3);
  localparam logic [STALL_W-1:0] STALL_DIV  = stall_upto(4);
  localparam logic [STALL_W-1:0] STALL_ALL  = stall_upto(STALL_W);

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / redirect controller.
// Generates per-register stall enables, a one-cycle flush with the redirect
// address for exceptions and ERET, and supervises multi-cycle divides with a
// sticky timeout flag.
// Ports:
//   cpu_clk_50M, cpu_rst_n   clock, asynchronous active-low reset
//   stallreq_id              load-use hazard from decode
//   stallreq_ibus            instruction fetch outstanding
//   div_start, div_ready     divide issue / completion pulses
//   dbus_wait                data bus transaction outstanding in mem
//   exc_req, eret_req        exception / ERET at mem (level, held until flush)
//   exc_vector, epc          handler address / ERET return address
//   stall                    per-register hold (combinational)
//   flush, flush_pc          registered one-cycle flush and redirect address
//   div_timeout              registered sticky divide timeout flag
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic               stallreq_id,
  input  logic               stallreq_ibus,
  input  logic               div_start,
  input  logic               div_ready,
  input  logic               dbus_wait,
  input  logic               exc_req,
  input  logic               eret_req,
  input  logic [WORD_W-1:0]  exc_vector,
  input  logic [WORD_W-1:0]  epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [WORD_W-1:0]  flush_pc,
  output logic               div_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  target_q, target_d;
  logic [WORD_W-1:0]  flush_pc_d;
  logic               flush_d;
  logic               div_timeout_d;
  logic               redirect_req;
  logic [WORD_W-1:0]  redirect_pc;
  logic               take_redirect;
  logic [STALL_W-1:0] stall_c;

  // Exception wins over ERET when both are raised in the same cycle.
  assign redirect_req  = exc_req | eret_req;
  assign redirect_pc   = exc_req ? exc_vector : epc;
  assign take_redirect = redirect_req &&
                         ((state_q == ST_RUN) || (state_q == ST_DIV_WAIT));

  // State register and registered outputs.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      target_q    <= ZERO_WORD;
      flush       <= 1'b0;
      flush_pc    <= PC_INIT;
      div_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      flush       <= flush_d;
      flush_pc    <= flush_pc_d;
      div_timeout <= div_timeout_d;
    end
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    target_d      = target_q;
    flush_pc_d    = flush_pc;
    div_timeout_d = div_timeout;

    if (take_redirect) begin
      // An in-flight divide is abandoned; mem cannot be flushed while its
      // bus transaction is outstanding, so the target is parked until then.
      if (dbus_wait) begin
        state_d  = ST_EXC_PEND;
        target_d = redirect_pc;
      end else begin
        state_d    = ST_FLUSH;
        flush_pc_d = redirect_pc;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (div_start && !dbus_wait) begin
            state_d = ST_DIV_WAIT;
            cnt_d   = '0;
          end
        end
        ST_DIV_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (div_ready) begin
            state_d = ST_RUN;
          end else if (cnt_q == CNT_LAST) begin
            state_d       = ST_RUN;
            div_timeout_d = 1'b1;
          end
        end
        ST_EXC_PEND: begin
          if (!dbus_wait) begin
            state_d    = ST_FLUSH;
            flush_pc_d = target_q;
          end
        end
        ST_FLUSH: begin
          state_d = ST_RUN;
        end
      endcase
    end

    flush_d = (state_d == ST_FLUSH);
  end

  // Stall priority encoder; first matching condition wins.
  always_comb begin
    stall_c = STALL_NONE;
    if (state_q == ST_FLUSH) begin
      stall_c = STALL_NONE;
    end else if ((state_q == ST_EXC_PEND) || ((state_q == ST_RUN) && redirect_req)) begin
      stall_c = STALL_ALL;
    end else if (dbus_wait) begin
      stall_c = STALL_ALL;
    end else if (((state_q == ST_DIV_WAIT) && !div_ready) ||
                 ((state_q == ST_RUN) && div_start)) begin
      stall_c = STALL_DIV;
    end else if (stallreq_id) begin
      stall_c = STALL_ID;
    end else if (stallreq_ibus) begin
      stall_c = STALL_IBUS;
    end
  end

  // Reset must release every register immediately, not at the next edge.
  assign stall = cpu_rst_n ? stall_c : STALL_NONE;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl. Stimulus pushes the
// hand-computed expected outputs of each cycle; a monitor on the falling
// edge pops and compares them against the DUT.
module tb_pipe_ctrl;

  localparam logic [4:0]  S_NONE = 5'b00000;
  localparam logic [4:0]  S_IBUS = 5'b00011;
  localparam logic [4:0]  S_ID   = 5'b00111;
  localparam logic [4:0]  S_DIV  = 5'b01111;
  localparam logic [4:0]  S_ALL  = 5'b11111;
  localparam logic [31:0] PCI    = 32'hBFC0_0000;
  localparam logic [31:0] VEC    = 32'hBFC0_0380;
  localparam logic [31:0] EPCV   = 32'h8000_1000;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n;
  logic        stallreq_id, stallreq_ibus, div_start, div_ready;
  logic        dbus_wait, exc_req, eret_req;
  logic [31:0] exc_vector, epc;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        div_timeout;

  pipe_ctrl dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .stallreq_id  (stallreq_id),
    .stallreq_ibus(stallreq_ibus),
    .div_start    (div_start),
    .div_ready    (div_ready),
    .dbus_wait    (dbus_wait),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .exc_vector   (exc_vector),
    .epc          (epc),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .div_timeout  (div_timeout)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  typedef struct {
    int          cyc;
    string       name;
    logic        chk_stall;
    logic [4:0]  stall;
    logic        flush;
    logic        chk_pc;
    logic [31:0] pc;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge cpu_clk_50M) cyc <= cyc + 1;

  task automatic cmp(input string name, input string field, input int c,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s cyc %0d %s got %h want %h", name, c, field, got, want);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge cpu_clk_50M) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        $display("FAIL %s stale entry cyc %0d seen at %0d", e.name, e.cyc, cyc);
      end else begin
        if (e.chk_stall) cmp(e.name, "stall", cyc, 32'(stall), 32'(e.stall));
        cmp(e.name, "flush", cyc, 32'(flush), 32'(e.flush));
        if (e.chk_pc) cmp(e.name, "flush_pc", cyc, flush_pc, e.pc);
        cmp(e.name, "div_timeout", cyc, 32'(div_timeout), 32'(e.to));
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic expect_out(input string name, input logic chk_stall, input logic [4:0] st,
                            input logic fl, input logic chk_pc, input logic [31:0] pc,
                            input logic to);
    exp_t e;
    e.cyc = cyc; e.name = name; e.chk_stall = chk_stall; e.stall = st;
    e.flush = fl; e.chk_pc = chk_pc; e.pc = pc; e.to = to;
    sb.push_back(e);
  endtask

  task automatic exp_run(input string name, input logic [4:0] st, input logic to);
    expect_out(name, 1'b1, st, 1'b0, 1'b0, 32'h0, to);
  endtask

  task automatic exp_flush(input string name, input logic [31:0] pc, input logic to);
    expect_out(name, 1'b1, S_NONE, 1'b1, 1'b1, pc, to);
  endtask

  initial begin
    cpu_rst_n = 1'b0; stallreq_id = 1'b0; stallreq_ibus = 1'b0;
    div_start = 1'b0; div_ready = 1'b0; dbus_wait = 1'b0;
    exc_req = 1'b0; eret_req = 1'b0; exc_vector = VEC; epc = 32'h0;

    // Reset values
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("reset", 1'b1, S_NONE, 1'b0, 1'b1, PCI, 1'b0);
    end
    tick(); cpu_rst_n = 1'b1; exp_run("post_reset", S_NONE, 1'b0);

    // Exception with idle data bus
    tick(); exc_req = 1'b1; exp_run("exc_req", S_ALL, 1'b0);
    tick(); exp_flush("exc_flush", VEC, 1'b0);
    tick(); exc_req = 1'b0; exp_run("exc_after", S_NONE, 1'b0);

    // Exception held off by bus wait; vector change must be ignored
    tick(); exc_req = 1'b1; dbus_wait = 1'b1; exp_run("pend_first", S_ALL, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(); exc_vector = 32'h0; exp_run("pend_wait", S_ALL, 1'b0);
    end
    tick(); dbus_wait = 1'b0; exp_run("pend_drop", S_ALL, 1'b0);
    tick(); exp_flush("pend_flush", VEC, 1'b0);
    tick(); exc_req = 1'b0; exc_vector = VEC; exp_run("pend_after", S_NONE, 1'b0);

    // Divide completing after 10 cycles, then a stray div_ready
    tick(); div_start = 1'b1; exp_run("div_start", S_DIV, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick(); div_start = 1'b0; exp_run("div_wait", S_DIV, 1'b0);
    end
    tick(); div_ready = 1'b1; exp_run("div_ready", S_NONE, 1'b0);
    tick(); div_ready = 1'b0; exp_run("div_done", S_NONE, 1'b0);
    tick(); div_ready = 1'b1; exp_run("stray_ready", S_NONE, 1'b0);
    tick(); div_ready = 1'b0; exp_run("stray_after", S_NONE, 1'b0);

    // Exception beats ERET; then ERET alone
    tick(); exc_req = 1'b1; eret_req = 1'b1; epc = EPCV; exp_run("both_req", S_ALL, 1'b0);
    tick(); exp_flush("both_flush", VEC, 1'b0);
    tick(); exc_req = 1'b0; eret_req = 1'b0; exp_run("both_after", S_NONE, 1'b0);
    tick(); eret_req = 1'b1; exp_run("eret_req", S_ALL, 1'b0);
    tick(); exp_flush("eret_flush", EPCV, 1'b0);
    tick(); eret_req = 1'b0; exp_run("eret_after", S_NONE, 1'b0);

    // Stall priority table
    tick(); stallreq_id = 1'b1; stallreq_ibus = 1'b1; exp_run("id_ibus", S_ID, 1'b0);
    tick(); stallreq_id = 1'b0; exp_run("ibus", S_IBUS, 1'b0);
    tick(); dbus_wait = 1'b1; exp_run("dbus_ibus", S_ALL, 1'b0);
    tick(); dbus_wait = 1'b0; stallreq_ibus = 1'b0; stallreq_id = 1'b1; exp_run("id", S_ID, 1'b0);
    tick(); div_start = 1'b1; exp_run("div_over_id", S_DIV, 1'b0);

    // Exception abandons an in-flight divide
    tick(); div_start = 1'b0; stallreq_id = 1'b0; exp_run("div_wait2", S_DIV, 1'b0);
    tick(); exc_req = 1'b1; expect_out("div_exc", 1'b0, S_NONE, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); exp_flush("div_exc_flush", VEC, 1'b0);
    tick(); exc_req = 1'b0; exp_run("div_exc_after", S_NONE, 1'b0);
    tick(); div_ready = 1'b1; exp_run("abandoned_ready", S_NONE, 1'b0);
    tick(); div_ready = 1'b0; exp_run("abandoned_after", S_NONE, 1'b0);

    // Asynchronous reset mid-DIV_WAIT
    tick(); div_start = 1'b1; exp_run("rd_start", S_DIV, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); div_start = 1'b0; exp_run("rd_wait", S_DIV, 1'b0);
    end
    tick(); cpu_rst_n = 1'b0; expect_out("rst_div", 1'b1, S_NONE, 1'b0, 1'b1, PCI, 1'b0);
    tick(); cpu_rst_n = 1'b1; exp_run("rst_div_rel", S_NONE, 1'b0);
    tick(); exp_run("rst_div_run", S_NONE, 1'b0);

    // Asynchronous reset mid-EXC_PEND: no flush afterwards
    tick(); exc_req = 1'b1; dbus_wait = 1'b1; exp_run("rp_req", S_ALL, 1'b0);
    tick(); exp_run("rp_pend", S_ALL, 1'b0);
    tick(); cpu_rst_n = 1'b0; exc_req = 1'b0; dbus_wait = 1'b0;
    expect_out("rst_pend", 1'b1, S_NONE, 1'b0, 1'b1, PCI, 1'b0);
    tick(); cpu_rst_n = 1'b1; exp_run("rst_pend_rel", S_NONE, 1'b0);
    tick(); exp_run("rst_pend_noflush", S_NONE, 1'b0);
    tick(); exp_run("rst_pend_noflush2", S_NONE, 1'b0);

    // Divide timeout: 40 waiting cycles, then sticky flag
    tick(); div_start = 1'b1; exp_run("to_start", S_DIV, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick(); div_start = 1'b0; exp_run("to_wait", S_DIV, 1'b0);
    end
    tick(); exp_run("to_set", S_NONE, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick(); exp_run("to_hold", S_NONE, 1'b1);
    end
    tick(); cpu_rst_n = 1'b0; expect_out("rst_to", 1'b1, S_NONE, 1'b0, 1'b1, PCI, 1'b0);
    tick(); cpu_rst_n = 1'b1; exp_run("rst_to_rel", S_NONE, 1'b0);

    tick(); tick();
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain %0d expectations left want 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
